// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: opcode encodings, FSM states and
// the offset helper used by the target adder.
package branch_resolver_pkg;

  localparam int unsigned FlushCyclesDefault = 2;

  localparam int unsigned OpW   = 6;
  localparam int unsigned DataW = 32;
  localparam int unsigned ImmW  = 16;

  localparam logic [OpW-1:0] OpBeq  = 6'b000100;
  localparam logic [OpW-1:0] OpBne  = 6'b000101;
  localparam logic [OpW-1:0] OpBgt  = 6'b010000;
  localparam logic [OpW-1:0] OpBgte = 6'b010001;
  localparam logic [OpW-1:0] OpBle  = 6'b010010;
  localparam logic [OpW-1:0] OpBleu = 6'b010011;
  localparam logic [OpW-1:0] OpBgtu = 6'b010100;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StResp,
    StFlush
  } state_e;

  // Word offset: sign-extend then scale to bytes.
  function automatic logic [DataW-1:0] branch_offset(input logic [ImmW-1:0] imm);
    return {{(DataW - ImmW - 2){imm[ImmW-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolver_cond.sv
// Combinational branch condition evaluation; flags any non-branch opcode as illegal.
module branch_cond
  import branch_resolver_pkg::*;
(
  input  logic [OpW-1:0]   opcode,
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  output logic             taken,
  output logic             illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (opcode)
      OpBeq:   taken = (a == b);
      OpBne:   taken = (a != b);
      OpBgt:   taken = ($signed(a) > $signed(b));
      OpBgte:  taken = ($signed(a) >= $signed(b));
      OpBle:   taken = ($signed(a) <= $signed(b));
      OpBleu:  taken = (a <= b);
      OpBgtu:  taken = (a > b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: accepts one branch request, evaluates it, holds the response
// until consumed and blocks new requests for a flush window after a taken branch.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FlushCyclesDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OpW-1:0]    opcode,
  input  logic [DataW-1:0]  a,
  input  logic [DataW-1:0]  b,
  input  logic [DataW-1:0]  pc,
  input  logic [ImmW-1:0]   imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [DataW-1:0]  target,
  output logic              illegal,
  output logic              redirect,
  output logic              flushing
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] FlushInit = CntW'(FLUSH_CYCLES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  state_e           state_q;
  logic [OpW-1:0]   opcode_q;
  logic [DataW-1:0] a_q;
  logic [DataW-1:0] b_q;
  logic [DataW-1:0] pc_q;
  logic [ImmW-1:0]  imm_q;
  logic [CntW-1:0]  flush_cnt_q;

  logic             cond_taken;
  logic             cond_illegal;
  logic [DataW-1:0] seq_pc;
  logic [DataW-1:0] jump_pc;

  branch_cond u_cond (
    .opcode  (opcode_q),
    .a       (a_q),
    .b       (b_q),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign seq_pc  = pc_q + 32'd4;
  assign jump_pc = seq_pc + branch_offset(imm_q);

  // in_ready is a registered function of state only, never of out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      target      <= '0;
      illegal     <= 1'b0;
      redirect    <= 1'b0;
      flushing    <= 1'b0;
      flush_cnt_q <= '0;
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
    end else begin
      redirect <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            opcode_q <= opcode;
            a_q      <= a;
            b_q      <= b;
            pc_q     <= pc;
            imm_q    <= imm;
            in_ready <= 1'b0;
            state_q  <= StEval;
          end
        end
        StEval: begin
          taken     <= cond_taken;
          illegal   <= cond_illegal;
          target    <= cond_taken ? jump_pc : seq_pc;
          out_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (taken) begin
              redirect <= 1'b1;
              if (FLUSH_CYCLES == 0) begin
                in_ready <= 1'b1;
                state_q  <= StIdle;
              end else begin
                flushing    <= 1'b1;
                flush_cnt_q <= FlushInit;
                state_q     <= StFlush;
              end
            end else begin
              in_ready <= 1'b1;
              state_q  <= StIdle;
            end
          end
        end
        StFlush: begin
          if (flush_cnt_q <= CntOne) begin
            flush_cnt_q <= '0;
            flushing    <= 1'b0;
            in_ready    <= 1'b1;
            state_q     <= StIdle;
          end else begin
            flush_cnt_q <= flush_cnt_q - CntOne;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: expected responses are queued when a
// request is driven and popped when the response appears.
module tb_branch_resolver;

  localparam int FC = 2;

  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] BGT  = 6'b010000;
  localparam logic [5:0] BGTE = 6'b010001;
  localparam logic [5:0] BLE  = 6'b010010;
  localparam logic [5:0] BLEU = 6'b010011;
  localparam logic [5:0] BGTU = 6'b010100;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] target;
  logic        illegal;
  logic        redirect;
  logic        flushing;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  branch_resolver #(.FLUSH_CYCLES(FC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .pc        (pc),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .target    (target),
    .illegal   (illegal),
    .redirect  (redirect),
    .flushing  (flushing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] pcv, input logic [15:0] immv);
    exp_t        e;
    logic [31:0] off;
    e.illegal = 1'b0;
    case (op)
      BEQ:     e.taken = (av == bv);
      BNE:     e.taken = (av != bv);
      BGT:     e.taken = ($signed(av) > $signed(bv));
      BGTE:    e.taken = ($signed(av) >= $signed(bv));
      BLE:     e.taken = ($signed(av) <= $signed(bv));
      BLEU:    e.taken = (av <= bv);
      BGTU:    e.taken = (av > bv);
      default: begin
        e.taken   = 1'b0;
        e.illegal = 1'b1;
      end
    endcase
    off      = 32'($signed(immv)) * 32'd4;
    e.target = e.taken ? (pcv + 32'd4 + off) : (pcv + 32'd4);
    return e;
  endfunction

  // hold: extra RESP cycles with out_ready low; abort: reset right after redirect.
  task automatic run_req(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] pcv, input logic [15:0] immv, input int hold,
                         input bit abort);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, in_ready}, 32'd1);
    opcode    = op;
    a         = av;
    b         = bv;
    pc        = pcv;
    imm       = immv;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    sb.push_back(model(op, av, bv, pcv, immv));
    @(negedge clk);
    in_valid = 1'b0;
    chk("eval_in_ready", {31'd0, in_ready}, 32'd0);
    chk("eval_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("resp_valid", {31'd0, out_valid}, 32'd1);
    e = sb.pop_front();
    chk("taken", {31'd0, taken}, {31'd0, e.taken});
    chk("target", target, e.target);
    chk("illegal", {31'd0, illegal}, {31'd0, e.illegal});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_taken", {31'd0, taken}, {31'd0, e.taken});
      chk("hold_target", target, e.target);
      chk("hold_illegal", {31'd0, illegal}, {31'd0, e.illegal});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("redirect", {31'd0, redirect}, {31'd0, e.taken});
    chk("flushing", {31'd0, flushing}, {31'd0, e.taken});
    chk("post_in_ready", {31'd0, in_ready}, {31'd0, !e.taken});
    if (e.taken && abort) begin
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_flushing", {31'd0, flushing}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      rst = 1'b0;
    end else if (e.taken) begin
      for (int k = 1; k < FC; k++) begin
        @(negedge clk);
        chk("flush_redirect", {31'd0, redirect}, 32'd0);
        chk("flush_active", {31'd0, flushing}, 32'd1);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      chk("flush_done_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_done_flag", {31'd0, flushing}, 32'd0);
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [31:0] ra;
    logic [31:0] rb;
    ops = '{BEQ, BNE, BGT, BGTE, BLE, BLEU, BGTU, 6'b111111};
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    a         = '0;
    b         = '0;
    pc        = '0;
    imm       = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_flushing", {31'd0, flushing}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_req(BEQ, 32'd5, 32'd5, 32'h100, 16'h0003, 0, 1'b0);
    run_req(BGTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 16'h0010, 0, 1'b0);
    run_req(BGT, 32'hFFFF_FFFF, 32'd1, 32'h200, 16'h0010, 0, 1'b0);
    run_req(BLEU, 32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 16'h8000, 0, 1'b0);
    run_req(6'b000000, 32'd7, 32'd7, 32'h300, 16'h0004, 0, 1'b0);
    run_req(BNE, 32'd1, 32'd2, 32'h400, 16'hFFFF, 4, 1'b0);
    run_req(BGTE, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 16'h0001, 0, 1'b0);
    run_req(BLE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 16'h0001, 1, 1'b0);
    run_req(BEQ, 32'd9, 32'd9, 32'h500, 16'h0002, 0, 1'b1);
    run_req(BNE, 32'd9, 32'd9, 32'h600, 16'h0002, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? ra : $urandom;
      run_req(ops[$urandom_range(0, 7)], ra, rb, $urandom, 16'($urandom),
              int'($urandom_range(0, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
